// File: rtl/sample_logger_pkg.sv
// sample_logger_pkg: shared sample width, filter latency and capture FSM encodings.
package sample_logger_pkg;
  localparam int WW_SAMPLE = 8;
  localparam int FIR_LATENCY = 3;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/simple_dp_ram.sv
// simple_dp_ram: one write port, one synchronous read-first read port, no reset.
module simple_dp_ram #(
  parameter int WW_DATA = 8,
  parameter int WW_ADDR = 10
) (
  input  logic               i_clock,
  input  logic               i_we,
  input  logic [WW_ADDR-1:0] i_wr_addr,
  input  logic [WW_DATA-1:0] i_wr_data,
  input  logic [WW_ADDR-1:0] i_rd_addr,
  output logic [WW_DATA-1:0] o_rd_data
);
  logic [WW_DATA-1:0] mem [2**WW_ADDR];
  always_ff @(posedge i_clock) begin
    if (i_we) mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= mem[i_rd_addr];
  end
endmodule

// File: rtl/sample_logger.sv
// sample_logger: captures one memory-full of filter output samples per i_run,
// aligning writes to the filter latency by delaying the upstream sample strobe.
module sample_logger
  import sample_logger_pkg::*;
#(
  parameter int WW_DATA = WW_SAMPLE,
  parameter int WW_ADDR = 10,
  parameter int DELAY   = FIR_LATENCY
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic signed [WW_DATA-1:0] i_data,
  input  logic                      i_run,
  input  logic        [WW_ADDR-1:0] i_rd_addr,
  output logic signed [WW_DATA-1:0] o_rd_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic        [WW_ADDR:0]   o_count
);
  localparam logic [WW_ADDR:0] LAST = (WW_ADDR+1)'(2**WW_ADDR - 1);
  state_t             state;
  logic [DELAY-1:0]   en_pipe;
  logic               en_d;
  logic               rd_ok;
  logic [WW_DATA-1:0] ram_q;
  assign en_d = en_pipe[DELAY-1];
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      en_pipe <= '0;
      rd_ok   <= 1'b0;
    end else begin
      en_pipe <= DELAY'({en_pipe, i_en});
      rd_ok   <= 1'b1;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      o_count <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (i_run) begin
          state   <= ST_CAPTURE;
          o_count <= '0;
          o_busy  <= 1'b1;
          o_done  <= 1'b0;
        end
        ST_CAPTURE: if (en_d) begin
          o_count <= o_count + 1'b1;
          if (o_count == LAST) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  simple_dp_ram #(.WW_DATA(WW_DATA), .WW_ADDR(WW_ADDR)) u_ram (
    .i_clock   (i_clock),
    .i_we      ((state == ST_CAPTURE) && en_d),
    .i_wr_addr (o_count[WW_ADDR-1:0]),
    .i_wr_data (i_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (ram_q)
  );
  // the RAM output register has no reset, so hold readback at zero until it has sampled once
  assign o_rd_data = rd_ok ? ram_q : '0;
endmodule

// File: tb/tb_sample_logger.sv
// tb_sample_logger: directed checks of capture sequencing, strobe alignment, reset abort and readback.
module tb_sample_logger;
  localparam int WD = 8;
  localparam int WA = 10;
  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_en = 1'b0;
  logic          i_run = 1'b0;
  logic [WD-1:0] i_data = '0;
  logic [WA-1:0] i_rd_addr = '0;
  logic [WD-1:0] o_rd_data;
  logic          o_busy;
  logic          o_done;
  logic [WA:0]   o_count;
  int n_vec = 0;
  int n_err = 0;
  always #5 i_clock = ~i_clock;
  sample_logger dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_data    (i_data),
    .i_run     (i_run),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_count   (o_count)
  );
  task automatic tick;
    @(posedge i_clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one i_en pulse; d is presented on the edge where the delayed strobe writes
  task automatic write_one(input logic [7:0] d);
    i_en = 1'b1;
    tick;
    i_en = 1'b0;
    tick;
    tick;
    i_data = d;
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_rd", 32'(o_rd_data), 0);
    i_reset = 1'b1;
    tick;
    write_one(8'h55);
    chk("idle_count", 32'(o_count), 0);
    chk("idle_busy", 32'(o_busy), 0);
    // V3: strobe alignment
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("run_busy", 32'(o_busy), 1);
    i_en = 1'b1;
    i_data = 8'hA0;
    tick;
    i_en = 1'b0;
    i_data = 8'hA1;
    tick;
    i_data = 8'hA2;
    tick;
    i_data = 8'hA3;
    tick;
    i_data = 8'hA4;
    chk("v3_count", 32'(o_count), 1);
    i_rd_addr = '0;
    tick;
    chk("v3_word0", 32'(o_rd_data), 'hA3);
    // V4: i_run ignored mid-capture
    for (int k = 1; k < 100; k++) write_one(k[7:0]);
    chk("v4_pre", 32'(o_count), 100);
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("v4_busy", 32'(o_busy), 1);
    chk("v4_hold", 32'(o_count), 100);
    write_one(8'h64);
    chk("v4_next", 32'(o_count), 101);
    // V5: asynchronous reset aborts capture
    for (int k = 101; k < 500; k++) write_one(k[7:0]);
    chk("v5_pre", 32'(o_count), 500);
    #2 i_reset = 1'b0;
    #1;
    chk("v5_busy", 32'(o_busy), 0);
    chk("v5_count", 32'(o_count), 0);
    chk("v5_done", 32'(o_done), 0);
    chk("v5_rd", 32'(o_rd_data), 0);
    tick;
    i_reset = 1'b1;
    tick;
    tick;
    chk("v5_idle", 32'(o_busy), 0);
    chk("v5_idle_cnt", 32'(o_count), 0);
    // V1: full capture
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    for (int k = 0; k < 1023; k++) write_one(k[7:0]);
    chk("v1_cnt1023", 32'(o_count), 1023);
    chk("v1_notdone", 32'(o_done), 0);
    write_one(8'hFF);
    chk("v1_done", 32'(o_done), 1);
    chk("v1_busy", 32'(o_busy), 0);
    chk("v1_count", 32'(o_count), 1024);
    for (int k = 0; k < 1024; k++) begin
      i_rd_addr = k[9:0];
      tick;
      chk("v1_mem", 32'(o_rd_data), k % 256);
    end
    // V2: strobe after full is discarded
    write_one(8'h7F);
    chk("v2_count", 32'(o_count), 1024);
    chk("v2_done", 32'(o_done), 1);
    i_rd_addr = '0;
    tick;
    chk("v2_mem0", 32'(o_rd_data), 0);
    // V6: read-first on same-address collision
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    chk("v6_done_clr", 32'(o_done), 0);
    chk("v6_count_clr", 32'(o_count), 0);
    chk("v6_busy", 32'(o_busy), 1);
    for (int k = 0; k < 5; k++) write_one(k[7:0] | 8'h20);
    write_one(8'h11);
    i_reset = 1'b0;
    tick;
    i_reset = 1'b1;
    tick;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    for (int k = 0; k < 5; k++) write_one(8'h00);
    i_rd_addr = 10'd5;
    write_one(8'h80);
    chk("v6_old", 32'(o_rd_data), 'h11);
    tick;
    chk("v6_new", 32'(o_rd_data), 'h80);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sample_logger.md
SAMPLE_LOGGER -- requirements
Module: sample_logger

Interface
REQ-001 Parameter WW_DATA, default 8, width of the logged sample (FIR output width).
REQ-002 Parameter WW_ADDR, default 10, memory address width; depth = 2**WW_ADDR.
REQ-003 Parameter DELAY, default 3, clocks between the upstream sample strobe and the matching valid filter output.
REQ-004 i_clock  input  1  single clock; all state on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_en  input  1  sample strobe, the same strobe that enables the upstream filter's shift register.
REQ-007 i_data  input  WW_DATA signed  filter output sample.
REQ-008 i_run  input  1  single-cycle start-capture request.
REQ-009 i_rd_addr  input  WW_ADDR  readback address.
REQ-010 o_rd_data  output  WW_DATA signed  readback data.
REQ-011 o_busy  output  1  high while capturing.
REQ-012 o_done  output  1  high once the memory is full, until the next accepted i_run.
REQ-013 o_count  output  WW_ADDR+1  number of samples written in the current or last capture.

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURE and DONE.
- IDLE -> CAPTURE on i_run=1.
- CAPTURE -> DONE on the write that makes o_count = 2**WW_ADDR.
- DONE -> CAPTURE on i_run=1.
REQ-015 i_run SHALL be ignored in CAPTURE.
REQ-016 Accepting i_run SHALL clear o_count and the write pointer to 0 and clear o_done on the same edge.
REQ-017 i_en SHALL be delayed through a DELAY-stage shift register (cleared by reset); the delayed strobe is en_d.
REQ-018 In CAPTURE, each cycle with en_d=1 SHALL write i_data to address o_count[WW_ADDR-1:0] and increment o_count by 1.
REQ-019 en_d pulses that arrive before i_run SHALL never be written. en_d is used whatever the state, with no realignment on i_run.
REQ-020 The write pointer SHALL never wrap: no writes occur in IDLE or DONE, and writes beyond depth are discarded.
REQ-021 An en_d on the cycle i_run is accepted SHALL NOT be written; capture begins with the next en_d.
REQ-022 o_busy SHALL be 1 exactly in CAPTURE, and o_done exactly in DONE.
REQ-023 Readback SHALL be synchronous: o_rd_data = mem[i_rd_addr sampled at edge N], valid after edge N+1.
REQ-024 Readback SHALL be allowed in every state.
REQ-025 A same-cycle read and write to one address SHALL return the old contents (read-first).
REQ-026 Samples SHALL be stored bit-exact, with no saturation or sign change.

Reset
REQ-027 While i_reset=0, the FSM SHALL go to IDLE, and o_count, the write pointer, the en_d pipeline and o_rd_data SHALL be 0.
REQ-028 Memory contents SHALL NOT be reset, to keep BRAM inference.
REQ-029 Reset during CAPTURE SHALL abort the capture immediately; already-written words are retained but undefined for verification.
REQ-030 After reset is released, the block SHALL wait in IDLE for i_run.

Structure
REQ-031 The shared include lab3_defs.vh SHALL hold:
- WW_SAMPLE (8), also used for the filter output width;
- FIR_LATENCY (3), the default for DELAY;
- the FSM state encodings.
REQ-032 Memory SHALL be a sub-module, simple_dp_ram (1 write port, 1 synchronous read-first read port, no reset).
REQ-033 The FSM, the strobe delay line and the counter SHALL reside in sample_logger.

Verification
REQ-034 Bench SHALL cover:
- V1: reset, i_run, then 1024 en_d pulses with i_data = index mod 256 (signed) -> o_done rises on the edge of write 1024; mem[k] = k mod 256; o_count = 1024.
- V2: a 1025th en_d after DONE -> no write; mem[0] unchanged; o_count stays 1024.
- V3: i_en pulses with DELAY=3 and i_run at cycle 0 -> the first stored word is the i_data present 3 clocks after the first i_en following i_run.
- V4: i_run pulsed again mid-CAPTURE at o_count = 100 -> ignored; o_count continues to 101 on the next en_d.
- V5: i_reset=0 asynchronously at o_count = 500 -> o_busy and o_count go to 0 before the next edge; state IDLE.
- V6: read address 5 while writing address 5 with 8'h80 (old 8'h11) -> o_rd_data = 8'h11 next cycle, and 8'h80 on a re-read.
